// File: rtl/cpu_seq.sv
// Multi-cycle CPU control sequencer: fetch/decode/execute FSM driving datapath strobes.
// Optional single-step fetch gating when CPU_SEQ_STEP_EN is defined (adds input 'step').
module cpu_seq #(
  parameter int unsigned MEM_TMO = 15
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CPU_SEQ_STEP_EN
  input  logic       step,
`endif
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       mem_rdy,
  output logic       mem_rd,
  output logic       ir_ld,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic       a_ld,
  output logic       g_ld,
  output logic       rf_we,
  output logic [1:0] rf_src,
  output logic [1:0] alu_op,
  output logic       busy,
  output logic       fault
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned ALU_W = 2;
  localparam int unsigned SRC_W = 2;

  localparam logic [SRC_W-1:0] SRC_MEM = SRC_W'(0);
  localparam logic [SRC_W-1:0] SRC_BUS = SRC_W'(1);
  localparam logic [SRC_W-1:0] SRC_G   = SRC_W'(2);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_MOV    = 4'd4,
    S_ALU1   = 4'd5,
    S_ALU2   = 4'd6,
    S_ALU3   = 4'd7,
    S_BRANCH = 4'd8,
    S_HALT   = 4'd9,
    S_FAULT  = 4'd10
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [ALU_W-1:0]   alu_q, alu_d;
  logic               fetch_go;
  logic               tmo_hit;
  logic               unused_instr_bits;

  // Operand/immediate bits belong to the datapath; only the opcode is decoded here.
  assign unused_instr_bits = ^instr[4:0];

  // Last allowed wait cycle: mem_rdy here is still accepted, its absence faults.
  assign tmo_hit = (wait_q == CNT_W'(MEM_TMO - 1));

`ifdef CPU_SEQ_STEP_EN
  logic armed_q, armed_d;

  // A step pulse seen in FETCH arms exactly one fetch; leaving FETCH disarms.
  assign fetch_go = armed_q | step;

  always_comb begin
    armed_d = 1'b0;
    if (state_q == S_FETCH && state_d == S_FETCH) begin
      armed_d = fetch_go;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end
`else
  assign fetch_go = 1'b1;
`endif

  // State and sequencing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      op_q    <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      alu_q   <= alu_d;
    end
  end

  // Next-state, wait counter, captured opcode and latched ALU op.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    op_d    = op_q;
    alu_d   = alu_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_go) begin
          if (mem_rdy) begin
            op_d    = instr[7:5];
            state_d = S_DECODE;
          end else if (tmo_hit) begin
            state_d = S_FAULT;
          end else begin
            wait_d = CNT_W'(wait_q + 1'b1);
          end
        end
      end
      S_DECODE: begin
        unique case (op_q)
          3'b000:  state_d = S_LOAD;
          3'b001:  state_d = S_MOV;
          3'b110:  state_d = S_BRANCH;
          3'b111:  state_d = S_HALT;
          default: begin
            alu_d   = ALU_W'(op_q - 3'd2);
            state_d = S_ALU1;
          end
        endcase
      end
      S_LOAD: begin
        if (mem_rdy) begin
          state_d = S_FETCH;
        end else if (tmo_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = CNT_W'(wait_q + 1'b1);
        end
      end
      S_MOV:    state_d = S_FETCH;
      S_ALU1:   state_d = S_ALU2;
      S_ALU2:   state_d = S_ALU3;
      S_ALU3:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_HALT: begin
        if (start) state_d = S_FETCH;
      end
      S_FAULT: begin
        if (start) state_d = S_FETCH;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobe decode; the FETCH/LOAD accept strobes qualify on mem_rdy in the same cycle.
  always_comb begin
    mem_rd = 1'b0;
    ir_ld  = 1'b0;
    pc_inc = 1'b0;
    pc_ld  = 1'b0;
    a_ld   = 1'b0;
    g_ld   = 1'b0;
    rf_we  = 1'b0;
    rf_src = SRC_MEM;
    alu_op = '0;
    busy   = 1'b0;
    fault  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          busy   = 1'b1;
          mem_rd = fetch_go;
          ir_ld  = fetch_go & mem_rdy;
          pc_inc = fetch_go & mem_rdy;
        end
        S_DECODE: busy = 1'b1;
        S_LOAD: begin
          busy   = 1'b1;
          mem_rd = 1'b1;
          rf_we  = mem_rdy;
          pc_inc = mem_rdy;
          rf_src = SRC_MEM;
        end
        S_MOV: begin
          busy   = 1'b1;
          rf_we  = 1'b1;
          rf_src = SRC_BUS;
        end
        S_ALU1: begin
          busy = 1'b1;
          a_ld = 1'b1;
        end
        S_ALU2: begin
          busy   = 1'b1;
          g_ld   = 1'b1;
          alu_op = alu_q;
        end
        S_ALU3: begin
          busy   = 1'b1;
          rf_we  = 1'b1;
          rf_src = SRC_G;
        end
        S_BRANCH: begin
          busy  = 1'b1;
          pc_ld = 1'b1;
        end
        S_FAULT:  fault = 1'b1;
        default:  busy  = 1'b0;
      endcase
    end
  end

  // Datapath hazards the decode must never produce.
  a_pc_excl: assert property (@(posedge clk) disable iff (rst) !(pc_inc && pc_ld));
  a_we_ir:   assert property (@(posedge clk) disable iff (rst) !(rf_we && ir_ld));

endmodule

// File: tb/tb_cpu_seq.sv
// Scoreboard bench for cpu_seq: per-cycle stimulus with expected strobe vectors.
// Build with CPU_SEQ_STEP_EN defined to also exercise single-step fetch gating.
module tb_cpu_seq;

  localparam int unsigned TMO = 4;

  // Expected-vector bit positions: {mem_rd,ir_ld,pc_inc,pc_ld,a_ld,g_ld,rf_we,rf_src,alu_op,busy,fault}
  localparam logic [12:0] MRD  = 13'h1000;
  localparam logic [12:0] IRL  = 13'h0800;
  localparam logic [12:0] PCI  = 13'h0400;
  localparam logic [12:0] PCL  = 13'h0200;
  localparam logic [12:0] ALD  = 13'h0100;
  localparam logic [12:0] GLD  = 13'h0080;
  localparam logic [12:0] RWE  = 13'h0040;
  localparam logic [12:0] SRC1 = 13'h0010;
  localparam logic [12:0] SRC2 = 13'h0020;
  localparam logic [12:0] BSY  = 13'h0002;
  localparam logic [12:0] FLT  = 13'h0001;
  localparam logic [12:0] FET  = MRD | IRL | PCI | BSY;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mem_rdy = 1'b0;
  logic [7:0] instr = 8'h00;
`ifdef CPU_SEQ_STEP_EN
  logic       step = 1'b1;
`endif
  logic       mem_rd, ir_ld, pc_inc, pc_ld, a_ld, g_ld, rf_we, busy, fault;
  logic [1:0] rf_src, alu_op;

  typedef struct {
    logic        r;
    logic        s;
    logic        m;
    logic        st;
    logic [7:0]  i;
    logic [12:0] exp;
    string       tag;
  } cyc_t;

  cyc_t        stim_q[$];
  logic [12:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cpu_seq #(.MEM_TMO(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef CPU_SEQ_STEP_EN
    .step    (step),
`endif
    .start   (start),
    .instr   (instr),
    .mem_rdy (mem_rdy),
    .mem_rd  (mem_rd),
    .ir_ld   (ir_ld),
    .pc_inc  (pc_inc),
    .pc_ld   (pc_ld),
    .a_ld    (a_ld),
    .g_ld    (g_ld),
    .rf_we   (rf_we),
    .rf_src  (rf_src),
    .alu_op  (alu_op),
    .busy    (busy),
    .fault   (fault)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {mem_rd, ir_ld, pc_inc, pc_ld, a_ld, g_ld, rf_we, rf_src, alu_op, busy, fault};
  endfunction

  task automatic cy_st(input logic r, input logic s, input logic m, input logic st,
                       input logic [7:0] i, input logic [12:0] e, input string t);
    cyc_t c;
    c.r = r; c.s = s; c.m = m; c.st = st; c.i = i; c.exp = e; c.tag = t;
    stim_q.push_back(c);
  endtask

  task automatic cy(input logic r, input logic s, input logic m,
                    input logic [7:0] i, input logic [12:0] e, input string t);
    cy_st(r, s, m, 1'b1, i, e, t);
  endtask

  task automatic fetch(input logic [7:0] i, input string t);
    cy(0, 0, 1, i, FET, t);
    cy(0, 0, 0, 8'h00, BSY, {t, "_decode"});
  endtask

  // Drive each queued cycle at negedge; expected enters the scoreboard, DUT output retires it.
  task automatic run();
    cyc_t c;
    while (stim_q.size() != 0) begin
      c = stim_q.pop_front();
      @(negedge clk);
      rst     = c.r;
      start   = c.s;
      mem_rdy = c.m;
      instr   = c.i;
`ifdef CPU_SEQ_STEP_EN
      step    = c.st;
`endif
      exp_q.push_back(c.exp);
      #1;
      check_val(c.tag, 32'(outs()), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with start and mem_rdy asserted: reset must win.
    cy(1, 1, 1, 8'hFF, '0, "rst_hold0");
    cy(1, 1, 1, 8'hFF, '0, "rst_hold1");
    cy(0, 1, 0, 8'h00, '0, "idle_after_rst");

    // add: fetch, decode, three ALU cycles; mem_rdy during ALU is ignored
    fetch(8'h40, "add_fetch");
    cy(0, 0, 1, 8'h00, ALD | BSY, "add_alu1");
    cy(0, 0, 1, 8'h00, GLD | BSY, "add_alu2");
    cy(0, 0, 0, 8'h00, RWE | SRC2 | BSY, "add_alu3");

    // load with mem_rdy arriving on the last allowed wait cycle
    cy(0, 0, 0, 8'h00, MRD | BSY, "ld_fetch_wait");
    cy(0, 0, 1, 8'h00, FET, "ld_fetch");
    cy(0, 0, 1, 8'h00, BSY, "ld_decode_rdy_ignored");
    cy(0, 0, 0, 8'h00, MRD | BSY, "ld_wait1");
    cy(0, 0, 0, 8'h00, MRD | BSY, "ld_wait2");
    cy(0, 0, 0, 8'h00, MRD | BSY, "ld_wait3");
    cy(0, 0, 1, 8'h00, MRD | RWE | PCI | BSY, "ld_accept");

    // xor / or / and with junk in the low instruction bits
    for (int k = 1; k <= 3; k++) begin
      fetch(8'((k + 2) << 5) | 8'(k), $sformatf("alu%0d_fetch", k));
      cy(0, 0, 0, 8'h00, ALD | BSY, $sformatf("alu%0d_a", k));
      cy(0, 0, 0, 8'h00, GLD | BSY | 13'(k << 2), $sformatf("alu%0d_g", k));
      cy(0, 0, 0, 8'h00, RWE | SRC2 | BSY, $sformatf("alu%0d_we", k));
    end

    // fetch timeout, then retry from FAULT into branch and halt
    for (int k = 0; k < int'(TMO); k++) cy(0, 0, 0, 8'h00, MRD | BSY, $sformatf("tmo_fetch%0d", k));
    cy(0, 0, 1, 8'h00, FLT, "fault_rdy_ignored");
    cy(0, 1, 0, 8'h00, FLT, "fault_start");
    fetch(8'hC0, "br_fetch");
    cy(0, 0, 0, 8'h00, PCL | BSY, "br_pcld");
    fetch(8'hE0, "halt_fetch");
    cy(0, 0, 0, 8'h00, '0, "halt0");
    cy(0, 0, 1, 8'h00, '0, "halt_rdy_ignored");
    cy(0, 1, 0, 8'h00, '0, "halt_start");

    // load timeout: no rf_we, then resume
    fetch(8'h00, "ldt_fetch");
    for (int k = 0; k < int'(TMO); k++) cy(0, 0, 0, 8'h00, MRD | BSY, $sformatf("tmo_load%0d", k));
    cy(0, 1, 0, 8'h00, FLT, "ldt_fault_start");

    // mov, then reset while in ALU2
    fetch(8'h20, "mov_fetch");
    cy(0, 0, 0, 8'h00, RWE | SRC1 | BSY, "mov_we");
    fetch(8'hA0, "rst_alu_fetch");
    cy(0, 0, 0, 8'h00, ALD | BSY, "rst_alu1");
    cy(1, 1, 1, 8'h00, '0, "rst_in_alu2");
    cy(0, 0, 0, 8'h00, '0, "rst_alu_idle");
    cy(0, 1, 0, 8'h00, '0, "rst_alu_idle_start");

    // reset mid-wait must clear the counter: full window available again
    cy(0, 0, 0, 8'h00, MRD | BSY, "mw_wait0");
    cy(0, 0, 0, 8'h00, MRD | BSY, "mw_wait1");
    cy(1, 0, 0, 8'h00, '0, "mw_rst");
    cy(0, 1, 0, 8'h00, '0, "mw_idle_start");
    for (int k = 0; k < int'(TMO) - 1; k++) cy(0, 0, 0, 8'h00, MRD | BSY, $sformatf("mw_rewait%0d", k));
    fetch(8'h20, "mw_last_cycle_fetch");
    cy(0, 0, 0, 8'h00, RWE | SRC1 | BSY, "mw_mov");

`ifdef CPU_SEQ_STEP_EN
    // step held low stalls FETCH without faulting; one pulse runs one instruction
    for (int k = 0; k < 2 * int'(TMO); k++) cy_st(0, 0, 1, 0, 8'h00, BSY, $sformatf("step_stall%0d", k));
    cy_st(0, 0, 0, 1, 8'h00, MRD | BSY, "step_pulse");
    cy_st(0, 0, 1, 0, 8'h20, FET, "step_fetch");
    cy_st(0, 0, 0, 0, 8'h00, BSY, "step_decode");
    cy_st(0, 0, 0, 0, 8'h00, RWE | SRC1 | BSY, "step_mov");
    cy_st(0, 0, 1, 0, 8'h00, BSY, "step_stall_again");
`endif

    run();
    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
